alu_8bit_sequencer: RTL and testbench
=====================================

Name: alu_8bit_sequencer

Overview:
- Sequential command front-end that drives the team's combinational 8-bit ALU core: operand_a, operand_b and the 4-bit operation code.
- Buffers incoming commands in a small FIFO and issues one per cycle to the ALU.
- Registers each result with a tag, carry and error status, and returns it over a valid/ready response channel.
- Sits between a bus-side command master and the ALU, and supplies backpressure in both directions.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of two, minimum 2.
- TAG_W, 4, width of the user tag carried from command to response.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_op  in  4  ALU operation code, same encoding as the ALU core (0000 add … 1111 equal).
- cmd_a  in  8  operand A.
- cmd_b  in  8  operand B.
- cmd_tag  in  TAG_W  user tag.
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  8  ALU result.
- rsp_carry  out  1  carry of the add.
- rsp_err  out  1  divide-by-zero flag.
- rsp_tag  out  TAG_W  tag of the originating command.
- busy  out  1  FIFO non-empty or rsp_valid high.
- ops_done  out  CNT_W  count of responses consumed, saturating.

Behaviour:
- Reset (rst=1 at a rising edge):
  - FIFO emptied; FSM to IDLE.
  - rsp_valid=0, rsp_result=0, rsp_carry=0, rsp_err=0, rsp_tag=0, ops_done=0, busy=0.
  - cmd_ready=1 from the following cycle.
  - Reset mid-operation discards all queued and held commands; no response is emitted for them.
- Push: occurs when cmd_valid && cmd_ready.
  - cmd_ready = (count < FIFO_DEPTH), computed from registered count only.
  - When full, no push is accepted even if a pop happens in the same cycle.
- Pop/issue: occurs when the FIFO is non-empty && (!rsp_valid || rsp_ready).
  - The FIFO head drives the ALU ports combinationally.
  - The ALU output is captured into the response register at that edge.
  - Simultaneous push and pop keep count unchanged; pointers wrap modulo FIFO_DEPTH.
- Latency:
  - Command accepted at edge E0 → rsp_valid high after edge E1.
  - Steady-state throughput is 1 response/cycle while rsp_ready=1.
- Response hold: while rsp_valid && !rsp_ready, all rsp_* outputs are held stable and no pop occurs.
- Status rules:
  - rsp_carry = ALU carry_out only when op=0000; 0 for every other op.
  - rsp_err = 1 when op=0011 && b==0; in that case rsp_result is forced to 8'hFF, not the ALU value.
  - Multiply returns the low 8 bits of the product. Sub wraps modulo 256.
- ops_done increments on each rsp_valid && rsp_ready handshake and saturates at all-ones.
- FSM, registered:
  - IDLE: FIFO empty, rsp_valid=0.
  - RUN: rsp_valid=1 and rsp_ready=1, or a pop pending.
  - STALL: rsp_valid=1 and rsp_ready=0.
  - Transitions:
    - IDLE→RUN on first pop.
    - RUN→STALL when rsp_ready=0 with rsp_valid=1.
    - STALL→RUN on rsp_ready=1.
    - RUN→IDLE when the FIFO is empty and the response is consumed.
  - The FSM drives busy and the pop enable.

Decomposition:
- Shared package alu_pkg holds:
  - 4-bit opcode constants: OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_NAND, OP_XNOR, OP_GT, OP_EQ.
  - FSM state encoding: IDLE, RUN, STALL.
  - Command struct typedef: op, a, b, tag.
- One sub-module is instantiated: the existing combinational ALU core alu_8bit.
- The FIFO stays inline as a circular buffer with read/write pointers and a count.

Test Plan:
- Reset then single command ADD a=8'hF0 b=8'h20 tag=3 → after 2 edges rsp_valid=1, result=8'h10, carry=1, err=0, tag=3; with rsp_ready=1, ops_done=1.
- Back-to-back SUB 5-7, MUL 8'h10*8'h11, ROL 8'h81, EQ 9==9, with rsp_ready=1 → consecutive responses 8'hFE, 8'h10, 8'h03, 8'h01, carry=0 on all, in order, one per cycle.
- DIV a=8'h40 b=0 → result=8'hFF, err=1. DIV a=8'h40 b=8'h04 → result=8'h10, err=0.
- rsp_ready=0, push 5 commands with FIFO_DEPTH=4:
  - 1 command sits in the response register and 4 fill the FIFO; cmd_ready=0 with the 5th pending; rsp_* stable, state STALL.
  - Raise rsp_ready → 5 responses drain in order, cmd_ready reasserts.
- Assert rst with 3 commands queued and rsp_valid=1 → next cycle rsp_valid=0, busy=0, ops_done=0, cmd_ready=1, and no stale response afterwards.
- Preload ops_done near all-ones (force 16'hFFFE), complete 3 handshakes → ops_done=16'hFFFF and stays there.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU core and its command sequencer.
package alu_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t OP_ADD  = 4'h0;
  localparam alu_op_t OP_SUB  = 4'h1;
  localparam alu_op_t OP_MUL  = 4'h2;
  localparam alu_op_t OP_DIV  = 4'h3;
  localparam alu_op_t OP_SHL  = 4'h4;
  localparam alu_op_t OP_SHR  = 4'h5;
  localparam alu_op_t OP_ROL  = 4'h6;
  localparam alu_op_t OP_ROR  = 4'h7;
  localparam alu_op_t OP_AND  = 4'h8;
  localparam alu_op_t OP_OR   = 4'h9;
  localparam alu_op_t OP_XOR  = 4'hA;
  localparam alu_op_t OP_NOR  = 4'hB;
  localparam alu_op_t OP_NAND = 4'hC;
  localparam alu_op_t OP_XNOR = 4'hD;
  localparam alu_op_t OP_GT   = 4'hE;
  localparam alu_op_t OP_EQ   = 4'hF;

  // Sequencer FSM encoding
  typedef logic [1:0] seq_state_t;
  localparam seq_state_t IDLE  = 2'd0;
  localparam seq_state_t RUN   = 2'd1;
  localparam seq_state_t STALL = 2'd2;

  // Widest user tag a command can carry; narrower tags are zero-extended.
  localparam int unsigned MAX_TAG_W = 16;

  typedef struct packed {
    alu_op_t              op;
    logic [7:0]           a;
    logic [7:0]           b;
    logic [MAX_TAG_W-1:0] tag;
  } alu_cmd_t;

  function automatic logic div_by_zero(alu_op_t op, logic [7:0] b);
    return (op == OP_DIV) && (b == 8'h00);
  endfunction

endpackage

// File: rtl/alu_8bit.sv
// Combinational 8-bit ALU core: 16 operations, carry from the adder.
module alu_8bit
  import alu_pkg::*;
(
  input  logic [7:0] operand_a,
  input  logic [7:0] operand_b,
  input  alu_op_t    op,
  output logic [7:0] result,
  output logic       carry_out
);

  logic [8:0]  sum;
  logic [15:0] prod;

  // Operation decode
  always_comb begin
    sum       = {1'b0, operand_a} + {1'b0, operand_b};
    prod      = {8'h00, operand_a} * {8'h00, operand_b};
    carry_out = sum[8];
    result    = 8'h00;
    case (op)
      OP_ADD:  result = sum[7:0];
      OP_SUB:  result = operand_a - operand_b;
      OP_MUL:  result = prod[7:0];
      // Divide by zero yields 0 here; the sequencer overrides it.
      OP_DIV:  result = (operand_b == 8'h00) ? 8'h00 : operand_a / operand_b;
      OP_SHL:  result = {operand_a[6:0], 1'b0};
      OP_SHR:  result = {1'b0, operand_a[7:1]};
      OP_ROL:  result = {operand_a[6:0], operand_a[7]};
      OP_ROR:  result = {operand_a[0], operand_a[7:1]};
      OP_AND:  result = operand_a & operand_b;
      OP_OR:   result = operand_a | operand_b;
      OP_XOR:  result = operand_a ^ operand_b;
      OP_NOR:  result = ~(operand_a | operand_b);
      OP_NAND: result = ~(operand_a & operand_b);
      OP_XNOR: result = ~(operand_a ^ operand_b);
      OP_GT:   result = {7'b0, operand_a > operand_b};
      OP_EQ:   result = {7'b0, operand_a == operand_b};
      default: result = 8'h00;
    endcase
  end

endmodule

// File: rtl/alu_8bit_sequencer.sv
// Command FIFO + issue logic in front of alu_8bit, with a registered
// valid/ready response channel and a saturating completion counter.
module alu_8bit_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_result,
  output logic             rsp_carry,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  localparam int unsigned PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  alu_cmd_t         mem_q [FIFO_DEPTH];
  alu_cmd_t         mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_result_q, rsp_result_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             rsp_err_q, rsp_err_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic [CNT_W-1:0] ops_done_q, ops_done_d;
  seq_state_t       state_q, state_d;

  alu_cmd_t   head;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       fifo_nz, push, pop, rsp_hs, dbz;

  // Head of the FIFO feeds the ALU directly
  assign head = mem_q[rptr_q];

  alu_8bit u_alu (
    .operand_a (head.a),
    .operand_b (head.b),
    .op        (head.op),
    .result    (alu_result),
    .carry_out (alu_carry)
  );

  // Handshake qualifiers and FSM-derived outputs
  always_comb begin
    fifo_nz   = (count_q != '0);
    cmd_ready = (count_q < FULL_CNT);
    push      = cmd_valid && cmd_ready;
    rsp_hs    = rsp_valid_q && rsp_ready;
    pop       = fifo_nz && (!rsp_valid_q || rsp_ready);
    // Outside IDLE the response register or the FIFO is always occupied
    busy      = (state_q != IDLE) || fifo_nz;
    dbz       = div_by_zero(head.op, head.b);
  end

  // FIFO pointer, count and storage update
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      mem_d[wptr_q] = '{op: cmd_op, a: cmd_a, b: cmd_b, tag: MAX_TAG_W'(cmd_tag)};
      wptr_d        = wptr_q + PTR_ONE;
    end
    if (pop) begin
      rptr_d = rptr_q + PTR_ONE;
    end
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!push && pop) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // Response register capture and completion counter
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_err_d    = rsp_err_q;
    rsp_tag_d    = rsp_tag_q;
    if (pop) begin
      rsp_valid_d  = 1'b1;
      rsp_result_d = dbz ? 8'hFF : alu_result;
      rsp_carry_d  = (head.op == OP_ADD) ? alu_carry : 1'b0;
      rsp_err_d    = dbz;
      rsp_tag_d    = head.tag[TAG_W-1:0];
    end else if (rsp_hs) begin
      rsp_valid_d = 1'b0;
    end
    ops_done_d = ops_done_q;
    if (rsp_hs && (ops_done_q != '1)) begin
      ops_done_d = ops_done_q + CNT_W'(1);
    end
  end

  // Sequencer FSM; a drained STALL drops straight to IDLE so busy never lags
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pop) state_d = RUN;
      end
      RUN: begin
        if (rsp_valid_q && !rsp_ready) begin
          state_d = STALL;
        end else if (!rsp_valid_d && (count_d == '0)) begin
          state_d = IDLE;
        end
      end
      STALL: begin
        if (rsp_ready) begin
          state_d = (!rsp_valid_d && (count_d == '0)) ? IDLE : RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and response state with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= 8'h00;
      rsp_carry_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_tag_q    <= '0;
      ops_done_q   <= '0;
      state_q      <= IDLE;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_err_q    <= rsp_err_d;
      rsp_tag_q    <= rsp_tag_d;
      ops_done_q   <= ops_done_d;
      state_q      <= state_d;
    end
  end

  // FIFO storage needs no reset: entries are only read once the count covers them
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_tag    = rsp_tag_q;
  assign ops_done   = ops_done_q;

endmodule

// File: tb/tb_alu_8bit_sequencer.sv
// Scoreboard bench for alu_8bit_sequencer: randomized and directed commands
// checked against an arithmetic reference model.
module tb_alu_8bit_sequencer;
  import alu_pkg::*;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned TAG_W      = 4;
  localparam int unsigned CNT_W      = 16;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [7:0]       cmd_a;
  logic [7:0]       cmd_b;
  logic [TAG_W-1:0] cmd_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_result;
  logic             rsp_carry;
  logic             rsp_err;
  logic [TAG_W-1:0] rsp_tag;
  logic             busy;
  logic [CNT_W-1:0] ops_done;

  alu_8bit_sequencer #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .TAG_W      (TAG_W),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_tag    (cmd_tag),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_err    (rsp_err),
    .rsp_tag    (rsp_tag),
    .busy       (busy),
    .ops_done   (ops_done)
  );

  typedef struct {
    logic [7:0]       res;
    logic             carry;
    logic             err;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t             sb[$];
  int               checks = 0;
  int               errors = 0;
  int               hs_cnt = 0;
  bit               mon_en = 0;
  logic [CNT_W-1:0] exp_ops = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference behaviour written as plain integer arithmetic
  function automatic exp_t ref_model(input logic [3:0] op, input logic [7:0] a,
                                     input logic [7:0] b, input logic [TAG_W-1:0] tag);
    int unsigned ua = a;
    int unsigned ub = b;
    exp_t e;
    e.res = 8'h00; e.carry = 1'b0; e.err = 1'b0; e.tag = tag;
    case (op)
      4'h0: begin e.res = 8'((ua + ub) % 256); e.carry = (ua + ub) > 255; end
      4'h1: e.res = 8'((ua + 256 - ub) % 256);
      4'h2: e.res = 8'((ua * ub) % 256);
      4'h3: begin
        if (ub == 0) begin e.res = 8'hFF; e.err = 1'b1; end
        else e.res = 8'(ua / ub);
      end
      4'h4: e.res = 8'((ua * 2) % 256);
      4'h5: e.res = 8'(ua / 2);
      4'h6: e.res = 8'((ua * 2) % 256 + ua / 128);
      4'h7: e.res = 8'(ua / 2 + (ua % 2) * 128);
      4'h8: e.res = a & b;
      4'h9: e.res = a | b;
      4'hA: e.res = a ^ b;
      4'hB: e.res = ~(a | b);
      4'hC: e.res = ~(a & b);
      4'hD: e.res = ~(a ^ b);
      4'hE: e.res = (ua > ub) ? 8'd1 : 8'd0;
      default: e.res = (ua == ub) ? 8'd1 : 8'd0;
    endcase
    return e;
  endfunction

  // Stimulus side of the scoreboard: record every accepted command
  always @(negedge clk) begin
    if (rst) sb.delete();
    else if (mon_en && cmd_valid && cmd_ready) sb.push_back(ref_model(cmd_op, cmd_a, cmd_b, cmd_tag));
  end

  // Response monitor: compare every consumed response and the counter
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (rst) begin
        exp_ops = '0;
      end else begin
        chk("ops_done", 32'(ops_done), 32'(exp_ops));
        if (rsp_valid && rsp_ready) begin
          if (sb.size() == 0) begin
            chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
          end else begin
            e = sb.pop_front();
            chk("rsp_result", 32'(rsp_result), 32'(e.res));
            chk("rsp_carry", 32'(rsp_carry), 32'(e.carry));
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
          end
          hs_cnt++;
          if (exp_ops != '1) exp_ops = exp_ops + 1'b1;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [TAG_W-1:0] tag);
    bit hs = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
    for (int n = 0; n < 100 && !hs; n++) begin
      hs = cmd_ready;
      tick(1);
    end
    cmd_valid = 1'b0;
    if (!hs) chk("send_timeout", 32'(cmd_ready), 32'd1);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 200; n++) begin
      if (!busy && sb.size() == 0) break;
      tick(1);
    end
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]       s_res;
    logic [TAG_W-1:0] s_tag;
    int               c0;
    bit               rdone;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
    rsp_ready = 1'b0;
    tick(2);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_result", 32'(rsp_result), 32'd0);
    chk("rst_carry", 32'(rsp_carry), 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_tag", 32'(rsp_tag), 32'd0);
    chk("rst_ops_done", 32'(ops_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    rst = 1'b0;
    mon_en = 1'b1;

    // Single ADD with latency check
    rsp_ready = 1'b1;
    send(OP_ADD, 8'hF0, 8'h20, 4'd3);
    chk("lat_e0_valid", 32'(rsp_valid), 32'd0);
    tick(1);
    chk("lat_e1_valid", 32'(rsp_valid), 32'd1);
    chk("add_result", 32'(rsp_result), 32'h10);
    chk("add_carry", 32'(rsp_carry), 32'd1);
    chk("add_tag", 32'(rsp_tag), 32'd3);
    tick(1);
    chk("add_ops_done", 32'(ops_done), 32'd1);
    wait_idle();

    // Back-to-back: one response per cycle
    send(OP_SUB, 8'd5, 8'd7, 4'd1);
    c0 = hs_cnt;
    send(OP_MUL, 8'h10, 8'h11, 4'd2);
    send(OP_ROL, 8'h81, 8'h00, 4'd4);
    send(OP_EQ, 8'd9, 8'd9, 4'd5);
    tick(2);
    chk("throughput", 32'(hs_cnt - c0), 32'd4);
    tick(1);
    chk("throughput_end", 32'(hs_cnt - c0), 32'd4);
    wait_idle();

    // Divide boundary
    send(OP_DIV, 8'h40, 8'h00, 4'd6);
    send(OP_DIV, 8'h40, 8'h04, 4'd7);
    wait_idle();

    // Backpressure: one held response plus a full FIFO
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(4'(8 + i), 8'(8'h30 + i), 8'(8'h0F * i), 4'(i + 8));
    chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("stall_state", 32'(dut.state_q), 32'(STALL));
    s_res = rsp_result; s_tag = rsp_tag;
    cmd_valid = 1'b1; cmd_op = OP_XOR; cmd_a = 8'h5A; cmd_b = 8'hA5; cmd_tag = 4'hD;
    tick(3);
    chk("full_hold_ready", 32'(cmd_ready), 32'd0);
    chk("hold_valid", 32'(rsp_valid), 32'd1);
    chk("hold_result", 32'(rsp_result), 32'(s_res));
    chk("hold_tag", 32'(rsp_tag), 32'(s_tag));
    chk("hold_state", 32'(dut.state_q), 32'(STALL));
    rsp_ready = 1'b1;
    send(OP_XOR, 8'h5A, 8'hA5, 4'hD);
    wait_idle();
    chk("drain_cmd_ready", 32'(cmd_ready), 32'd1);

    // Reset while commands are queued and a response is held
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(OP_ADD, 8'(i), 8'd1, 4'(i));
    chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ops", 32'(ops_done), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
    rsp_ready = 1'b1;
    tick(5);
    chk("no_stale_rsp", 32'(rsp_valid), 32'd0);

    // Random traffic with random backpressure
    rdone = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [7:0] rb;
          rb = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
          send(4'($urandom_range(0, 15)), 8'($urandom), rb, 4'($urandom));
          if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 2));
        end
        rdone = 1;
      end
      begin
        while (!rdone) begin
          rsp_ready = ($urandom_range(0, 3) != 0);
          tick(1);
        end
      end
    join
    rsp_ready = 1'b1;
    wait_idle();

    // Counter saturation
    force dut.ops_done_q = 16'hFFFE;
    exp_ops = 16'hFFFE;
    tick(1);
    release dut.ops_done_q;
    chk("sat_preload", 32'(ops_done), 32'hFFFE);
    for (int i = 0; i < 3; i++) send(OP_OR, 8'(i), 8'h80, 4'(i));
    wait_idle();
    chk("sat_ffff", 32'(ops_done), 32'hFFFF);
    send(OP_AND, 8'hFF, 8'h0F, 4'd9);
    wait_idle();
    chk("sat_hold", 32'(ops_done), 32'hFFFF);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
